fu_mem_pipe: RTL

//  Parametrised memory functional unit for the out-of-order core: accepts tagged

---
 rtl/fu_mem_pipe.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/fu_mem_pipe.sv
// fu_mem_pipe: queued, tagged load/store unit with an internal word RAM.
// Requests enter a DEPTH-entry FIFO. A single engine takes them in order,
// waits LATENCY cycles, performs the RAM access and holds the tagged result
// for the CDB until it is granted.
module fu_mem_pipe #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 3,
    parameter int ADDR_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    // Handshakes:
    //  - A request transfers on a rising edge where req_valid && req_ready.
    //    req_ready depends only on queue occupancy, never on req_valid.
    //  - A result transfers on a rising edge where res_valid && res_ack.
    //    res_ack is ignored while res_valid is low. All res_* outputs stay
    //    stable from the cycle res_valid rises until that transfer.
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             req_mem_w,
    input  logic [2:0]       req_bhw,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [31:0]      req_imm,
    output logic             res_valid,
    input  logic             res_ack,
    output logic [TAG_W-1:0] res_tag,
    output logic [31:0]      res_data,
    output logic             res_store,
    output logic             res_err,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             mem_w;
        logic [2:0]       bhw;
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic [31:0]      imm;
    } req_t;

    // Request queue
    req_t             q_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   q_count;
    logic             q_full;
    logic             q_empty;
    logic             enq;
    logic             pop;

    // Engine
    state_t           state;
    state_t           state_nx;
    req_t             eng;
    logic [CNT_W-1:0] cnt;
    logic             access;

    // Access datapath
    logic [31:0]       eng_addr;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        off;
    logic [31:0]       rd_word;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [31:0]       load_data;
    logic              acc_err;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              unused_addr_bits;

    logic [31:0] ram [2**ADDR_W];

    assign q_full  = (q_count == (PTR_W+1)'(DEPTH));
    assign q_empty = (q_count == '0);
    assign enq     = req_valid && !q_full;
    assign access  = (state == S_BUSY) && (cnt == CNT_W'(LATENCY - 1));

    // Queue storage: write the incoming request at the tail
    always_ff @(posedge clk) begin
        if (enq) begin
            q_mem[wr_ptr] <= '{tag: req_tag, mem_w: req_mem_w, bhw: req_bhw,
                               rs1: req_rs1, rs2: req_rs2, imm: req_imm};
        end
    end

    // Queue pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, pop})
                2'b10:   q_count <= q_count + (PTR_W+1)'(1);
                2'b01:   q_count <= q_count - (PTR_W+1)'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // FSM next state: take the head when free, finish after LATENCY, wait for grant
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (!q_empty) state_nx = S_BUSY;
            S_BUSY:  if (access)   state_nx = S_DONE;
            S_DONE:  if (res_ack)  state_nx = q_empty ? S_IDLE : S_BUSY;
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM outputs: pop strobe, result valid, status flags
    always_comb begin
        pop       = !q_empty && ((state == S_IDLE) || ((state == S_DONE) && res_ack));
        res_valid = (state == S_DONE);
        busy      = !q_empty || (state != S_IDLE);
        req_ready = !q_full;
        dbg_state = state;
    end

    // Engine request register, loaded from the queue head on pop
    always_ff @(posedge clk) begin
        if (pop) eng <= q_mem[rd_ptr];
    end

    // Latency counter, restarted on every pop
    always_ff @(posedge clk) begin
        if (rst)                   cnt <= '0;
        else if (pop)              cnt <= '0;
        else if (state == S_BUSY)  cnt <= cnt + CNT_W'(1);
    end

    // Effective address; bits above the RAM index alias onto the same word
    assign eng_addr         = eng.rs1 + eng.imm;
    assign word_idx         = eng_addr[ADDR_W+1:2];
    assign off              = eng_addr[1:0];
    assign unused_addr_bits = ^eng_addr[31:ADDR_W+2];
    assign rd_word          = ram[word_idx];
    assign sel_byte         = rd_word[{off, 3'b000} +: 8];
    assign sel_half         = off[1] ? rd_word[31:16] : rd_word[15:0];

    // Misalignment / illegal size detection
    always_comb begin
        acc_err = 1'b0;
        case (eng.bhw)
            3'b000:  acc_err = 1'b0;
            3'b001:  acc_err = off[0];
            3'b010:  acc_err = |off;
            3'b100:  acc_err = eng.mem_w;
            3'b101:  acc_err = eng.mem_w | off[0];
            default: acc_err = 1'b1;
        endcase
    end

    // Load lane selection with sign or zero extension
    always_comb begin
        load_data = '0;
        case (eng.bhw)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, sel_byte};
            3'b101:  load_data = {16'd0, sel_half};
            default: load_data = '0;
        endcase
    end

    // Store byte enables and replicated write data
    always_comb begin
        be    = 4'b0000;
        wdata = eng.rs2;
        case (eng.bhw[1:0])
            2'b00: begin
                be    = 4'b0001 << off;
                wdata = {4{eng.rs2[7:0]}};
            end
            2'b01: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{eng.rs2[15:0]}};
            end
            2'b10: begin
                be    = 4'b1111;
                wdata = eng.rs2;
            end
            default: be = 4'b0000;
        endcase
    end

    // RAM write: only on the access cycle of a legal store, only enabled lanes
    always_ff @(posedge clk) begin
        if (access && eng.mem_w && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Result registers, captured on the access cycle and held until the next access
    always_ff @(posedge clk) begin
        if (rst) begin
            res_tag   <= '0;
            res_data  <= '0;
            res_store <= 1'b0;
            res_err   <= 1'b0;
        end else if (access) begin
            res_tag   <= eng.tag;
            res_store <= eng.mem_w;
            res_err   <= acc_err;
            res_data  <= (eng.mem_w || acc_err) ? 32'd0 : load_data;
        end
    end

endmodule
